sram_fifo_ctrl: RTL and testbench
=================================

Name: sram_fifo_ctrl

Overview:
- Synchronous show-ahead FIFO controller that drives an external one-write/one-read SRAM macro (the rfdp<DEPTH>x<WIDTH> family).
- Uses the macro's port A for reads and port B for writes; both enables are active-low.
- Hides the macro's 1-cycle read latency behind a 2-entry registered output buffer, so the consumer sees a valid/ready stream.
- Used as the line/feature buffer between the camera pixel path and the CNN engine. Instantiated beside its SRAM; both SRAM clocks tie to clk.

Parameters:
- DEPTH, 256, SRAM word count; power of two, >= 4.
- WIDTH, 96, data word width in bits.
- AW, $clog2(DEPTH), SRAM address width (derived; do not override).

Ports:
- clk  input  1  single clock for the controller and both SRAM ports.
- rstn  input  1  asynchronous active-low reset.
- clr  input  1  synchronous flush; empties the FIFO.
- wr_valid  input  1  producer has a word.
- wr_ready  output  1  FIFO can accept a word (mem_cnt < DEPTH).
- wr_data  input  WIDTH  producer word.
- rd_valid  output  1  rd_data holds a valid head word.
- rd_ready  input  1  consumer takes the head word.
- rd_data  output  WIDTH  head word; registered.
- count  output  AW+2  total occupancy = mem_cnt + inflight + out_cnt; range 0..DEPTH+2.
- ram_aa  output  AW  SRAM read address (= rd_ptr).
- ram_cena  output  1  SRAM read enable, active-low.
- ram_qa  input  WIDTH  SRAM read data; valid the cycle after ram_cena low.
- ram_ab  output  AW  SRAM write address (= wr_ptr).
- ram_db  output  WIDTH  SRAM write data (= wr_data).
- ram_cenb  output  1  SRAM write enable, active-low.

Behaviour:
- Reset (rstn low, async):
  - wr_ptr, rd_ptr, mem_cnt, inflight, out_cnt cleared.
  - rd_valid=0, rd_data=0, count=0.
  - ram_cena=1, ram_cenb=1.
  - wr_ready=1 once state is cleared.
- Handshake events:
  - push = wr_valid & wr_ready.
  - pop = rd_valid & rd_ready.
  - Signals are accepted on the rising edge; wr_data need not be held after a push.
- Write path (combinational drive):
  - ram_cenb = ~push, ram_ab = wr_ptr, ram_db = wr_data.
  - On push, wr_ptr increments and wraps DEPTH-1 -> 0.
- Read issue:
  - issue = (mem_cnt != 0) & (out_cnt + inflight - pop < 2).
  - ram_cena = ~issue, ram_aa = rd_ptr.
  - On issue, rd_ptr increments (wraps) and inflight is set for exactly one cycle.
- Capture:
  - In the cycle after issue, ram_qa is written into the output buffer tail.
  - The output buffer shifts on pop. Pop and capture in the same cycle are legal, with out_cnt unchanged.
- Output:
  - rd_valid = (out_cnt != 0); rd_data = buffer head.
  - rd_data is stable while rd_valid & ~rd_ready.
- mem_cnt update: +push, -issue, both in the same cycle allowed.
- Address collision: impossible by construction.
  - A read is only issued when mem_cnt > 0; a write only when mem_cnt < DEPTH.
  - So rd_ptr and wr_ptr never address the same word in the same cycle.
- Latency:
  - push at cycle t into an empty FIFO -> issue at t+1 -> capture at t+2 -> rd_valid at t+3.
  - Sustained throughput: 1 word/cycle in and out.
- Full: when mem_cnt == DEPTH, wr_ready=0 and the SRAM is not written. count may reach DEPTH+2.
- Empty: rd_valid=0; pop is ignored. A rd_ready asserted while empty has no effect.
- Simultaneous push and pop when full: the pop frees output space, the resulting issue lowers mem_cnt next cycle, and wr_ready recovers one cycle later. wr_ready is never combinationally dependent on rd_ready.
- clr (synchronous, priority over push/pop/issue):
  - All pointers and counts go to 0, rd_valid=0 next cycle.
  - ram_cena=1 and ram_cenb=1 during the clr cycle.
  - Data from an in-flight read is discarded, not captured.
- Reset mid-operation: asynchronous clear as above. SRAM contents are don't-care afterwards.

Test Plan:
- Reset, then push 0x01 at cycle 0 with rd_ready=1 -> ram_cena low at cycle 1 with ram_aa=0; rd_valid high at cycle 3 with rd_data=0x01; count goes 1,1,1,1,0.
- DEPTH=8, rd_ready=0, push 0..11 continuously -> 10 accepted (8 in SRAM + 2 buffered); wr_ready=0 after the 10th; count=10; ram_cenb never low while wr_ready=0.
- From full, assert rd_ready=1 with wr_valid=1 -> output order 0,1,2,... with no loss or duplication; ram_ab and ram_aa both wrap 7->0; at steady state one push and one pop per cycle.
- Random wr_valid/rd_ready (50%) for 10k words, DEPTH=8 -> output sequence equals input sequence; count always equals pushes minus pops; rd_data stable while stalled.
- Assert clr the cycle after an issue with 3 words stored -> the in-flight word is never output; rd_valid=0 and count=0 next cycle; next push 0xAA is the first word read out.
- Drop rstn asynchronously mid-burst -> ram_cena=ram_cenb=1 and rd_valid=0 immediately, without a clock edge; normal operation resumes after release.

Source files
------------

// File: rtl/sram_fifo_ctrl.sv
// rtl/sram_fifo_ctrl.sv - show-ahead FIFO controller around a 1R1W SRAM macro
// A 2-entry output buffer absorbs the macro's 1-cycle read latency.
module sram_fifo_ctrl #(
    parameter int DEPTH = 256,
    parameter int WIDTH = 96,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clr,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [WIDTH-1:0] wr_data,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [WIDTH-1:0] rd_data,
    output logic [AW+1:0]    count,
    output logic [AW-1:0]    ram_aa,
    output logic             ram_cena,
    input  logic [WIDTH-1:0] ram_qa,
    output logic [AW-1:0]    ram_ab,
    output logic [WIDTH-1:0] ram_db,
    output logic             ram_cenb
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      mem_cnt_q, mem_cnt_d;
    logic             inflight_q, inflight_d;
    logic [1:0]       out_cnt_q, out_cnt_d;
    logic [WIDTH-1:0] buf0_q, buf0_d;
    logic [WIDTH-1:0] buf1_q, buf1_d;
    logic             wr_ready_q, wr_ready_d;

    logic             push, pop, issue;
    logic [2:0]       occ_after;
    logic [1:0]       cap_slot;

    // wr_ready is registered so it never follows rd_ready combinationally
    // and stays low while reset is held.
    assign wr_ready = wr_ready_q;
    assign rd_valid = (out_cnt_q != 2'd0);
    assign rd_data  = buf0_q;

    assign push      = wr_valid & wr_ready_q & ~clr;
    assign pop       = rd_valid & rd_ready;
    assign occ_after = {1'b0, out_cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
    assign cap_slot  = out_cnt_q - {1'b0, pop};
    assign issue     = ~clr & (mem_cnt_q != '0) & (occ_after < 3'd2);

    assign ram_cenb = ~push;
    assign ram_ab   = wr_ptr_q;
    assign ram_db   = wr_data;
    assign ram_cena = ~issue;
    assign ram_aa   = rd_ptr_q;

    assign count = (AW+2)'(mem_cnt_q) + (AW+2)'(inflight_q) + (AW+2)'(out_cnt_q);

    always_comb begin
        wr_ptr_d   = wr_ptr_q + (push ? 1'b1 : 1'b0);
        rd_ptr_d   = rd_ptr_q + (issue ? 1'b1 : 1'b0);
        mem_cnt_d  = mem_cnt_q + (push ? 1'b1 : 1'b0) - (issue ? 1'b1 : 1'b0);
        inflight_d = issue;
        out_cnt_d  = occ_after[1:0];
        buf0_d     = buf0_q;
        buf1_d     = buf1_q;
        if (pop) begin
            buf0_d = buf1_q;
        end
        // Returning read data lands behind whatever survives this cycle's pop.
        if (inflight_q) begin
            if (cap_slot == 2'd0) begin
                buf0_d = ram_qa;
            end else begin
                buf1_d = ram_qa;
            end
        end
        if (clr) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            mem_cnt_d  = '0;
            inflight_d = 1'b0;
            out_cnt_d  = 2'd0;
        end
        wr_ready_d = (mem_cnt_d != FULL_CNT);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            mem_cnt_q  <= '0;
            inflight_q <= 1'b0;
            out_cnt_q  <= 2'd0;
            buf0_q     <= '0;
            buf1_q     <= '0;
            wr_ready_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            mem_cnt_q  <= mem_cnt_d;
            inflight_q <= inflight_d;
            out_cnt_q  <= out_cnt_d;
            buf0_q     <= buf0_d;
            buf1_q     <= buf1_d;
            wr_ready_q <= wr_ready_d;
        end
    end

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// tb/tb_sram_fifo_ctrl.sv - self-checking bench for sram_fifo_ctrl
// Directed vector table plus fill/drain, random, clr and async-reset sequences.
module tb_sram_fifo_ctrl;

    localparam int DEPTH = 8;
    localparam int WIDTH = 16;
    localparam int AW    = 3;

    logic             clk = 1'b0;
    logic             rstn, clr, wr_valid, wr_ready, rd_valid, rd_ready;
    logic [WIDTH-1:0] wr_data, rd_data, ram_qa, ram_db;
    logic [AW+1:0]    count;
    logic [AW-1:0]    ram_aa, ram_ab;
    logic             ram_cena, ram_cenb;

    int checks = 0;
    int errors = 0;

    sram_fifo_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk(clk), .rstn(rstn), .clr(clr),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .count(count),
        .ram_aa(ram_aa), .ram_cena(ram_cena), .ram_qa(ram_qa),
        .ram_ab(ram_ab), .ram_db(ram_db), .ram_cenb(ram_cenb)
    );

    always #5 clk = ~clk;

    // Behavioural model of the rfdp macro: registered read on port A, write on port B.
    logic [WIDTH-1:0] sram [DEPTH];
    always @(posedge clk) begin
        if (!ram_cena) ram_qa <= sram[ram_aa];
        if (!ram_cenb) sram[ram_ab] <= ram_db;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic             clr;
        logic             wv;
        logic [WIDTH-1:0] wd;
        logic             rr;
        logic             e_wrdy;
        logic             e_rv;
        logic [WIDTH-1:0] e_rd;
        logic [AW+1:0]    e_cnt;
        logic             e_cena;
        logic             e_cenb;
        logic [AW-1:0]    e_aa;
        logic [AW-1:0]    e_ab;
    } vec_t;

    vec_t vecs [14];

    function automatic vec_t mk(input logic c, input logic wv, input logic [15:0] wd, input logic rr,
                                input logic wrdy, input logic rv, input logic [15:0] rd,
                                input logic [4:0] cnt, input logic cena, input logic cenb,
                                input logic [2:0] aa, input logic [2:0] ab);
        vec_t v;
        v.clr = c; v.wv = wv; v.wd = wd; v.rr = rr;
        v.e_wrdy = wrdy; v.e_rv = rv; v.e_rd = rd; v.e_cnt = cnt;
        v.e_cena = cena; v.e_cenb = cenb; v.e_aa = aa; v.e_ab = ab;
        return v;
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            clr = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0;
        end
    endtask

    logic [WIDTH-1:0] q [$];
    logic [WIDTH-1:0] exp_w, prev_data;
    int accepted, viol, pops, cyc, steady;
    logic saw_ab7, saw_aa7, ab_wrap, aa_wrap, prev_stall, got;

    initial begin
        rstn = 1'b0; clr = 1'b0; wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;

        //      clr wv  wd     rr  wrdy rv rd     cnt cena cenb aa ab
        vecs[0]  = mk(0, 1, 16'h01, 1, 1, 0, 16'h0, 0, 1, 0, 0, 0);
        vecs[1]  = mk(0, 0, 16'h00, 1, 1, 0, 16'h0, 1, 0, 1, 0, 0);
        vecs[2]  = mk(0, 0, 16'h00, 1, 1, 0, 16'h0, 1, 1, 1, 0, 0);
        vecs[3]  = mk(0, 0, 16'h00, 1, 1, 1, 16'h01, 1, 1, 1, 0, 0);
        vecs[4]  = mk(0, 0, 16'h00, 1, 1, 0, 16'h0, 0, 1, 1, 0, 0);
        vecs[5]  = mk(0, 1, 16'hA0, 0, 1, 0, 16'h0, 0, 1, 0, 0, 1);
        vecs[6]  = mk(0, 1, 16'hA1, 0, 1, 0, 16'h0, 1, 0, 0, 1, 2);
        vecs[7]  = mk(0, 1, 16'hA2, 0, 1, 0, 16'h0, 2, 0, 0, 2, 3);
        vecs[8]  = mk(1, 0, 16'h00, 0, 1, 1, 16'hA0, 3, 1, 1, 0, 0);
        vecs[9]  = mk(0, 1, 16'hAA, 1, 1, 0, 16'h0, 0, 1, 0, 0, 0);
        vecs[10] = mk(0, 0, 16'h00, 1, 1, 0, 16'h0, 1, 0, 1, 0, 0);
        vecs[11] = mk(0, 0, 16'h00, 1, 1, 0, 16'h0, 1, 1, 1, 0, 0);
        vecs[12] = mk(0, 0, 16'h00, 1, 1, 1, 16'hAA, 1, 1, 1, 0, 0);
        vecs[13] = mk(0, 0, 16'h00, 1, 1, 0, 16'h0, 0, 1, 1, 0, 0);

        // Reset state
        #3;
        chk("reset_rd_valid", 32'(rd_valid), 0);
        chk("reset_count", 32'(count), 0);
        chk("reset_cena", 32'(ram_cena), 1);
        chk("reset_cenb", 32'(ram_cenb), 1);
        @(negedge clk); rstn = 1'b1;
        idle(2);
        chk("wr_ready_after_reset", 32'(wr_ready), 1);

        // Directed table: latency, then clr discarding an in-flight read
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            clr = vecs[i].clr; wr_valid = vecs[i].wv; wr_data = vecs[i].wd; rd_ready = vecs[i].rr;
            #1;
            chk($sformatf("v%0d_wr_ready", i), 32'(wr_ready), 32'(vecs[i].e_wrdy));
            chk($sformatf("v%0d_rd_valid", i), 32'(rd_valid), 32'(vecs[i].e_rv));
            chk($sformatf("v%0d_count", i), 32'(count), 32'(vecs[i].e_cnt));
            chk($sformatf("v%0d_cena", i), 32'(ram_cena), 32'(vecs[i].e_cena));
            chk($sformatf("v%0d_cenb", i), 32'(ram_cenb), 32'(vecs[i].e_cenb));
            if (vecs[i].e_rv) chk($sformatf("v%0d_rd_data", i), 32'(rd_data), 32'(vecs[i].e_rd));
            if (!vecs[i].e_cena) chk($sformatf("v%0d_ram_aa", i), 32'(ram_aa), 32'(vecs[i].e_aa));
            if (!vecs[i].e_cenb) chk($sformatf("v%0d_ram_ab", i), 32'(ram_ab), 32'(vecs[i].e_ab));
        end

        // Fill to full with the consumer stalled
        @(negedge clk); rstn = 1'b0; clr = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0;
        @(negedge clk); rstn = 1'b1;
        idle(2);
        accepted = 0; viol = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            wr_valid = 1'b1; wr_data = 16'(accepted); rd_ready = 1'b0;
            #1;
            if (!wr_ready && !ram_cenb) viol++;
            if (wr_ready) begin
                q.push_back(wr_data);
                accepted++;
            end
        end
        chk("full_accepted", 32'(accepted), 10);
        chk("full_count", 32'(count), 10);
        chk("full_wr_ready", 32'(wr_ready), 0);
        chk("full_cenb_while_not_ready", 32'(viol), 0);
        chk("full_head", 32'(rd_data), 0);

        // Drain from full while still pushing: order, wrap, steady state
        saw_ab7 = 0; saw_aa7 = 0; ab_wrap = 0; aa_wrap = 0; steady = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            wr_valid = 1'b1; wr_data = 16'(accepted); rd_ready = 1'b1;
            #1;
            if (!ram_cenb) begin
                if (saw_ab7 && ram_ab == 3'd0) ab_wrap = 1;
                saw_ab7 = (ram_ab == 3'd7);
            end
            if (!ram_cena) begin
                if (saw_aa7 && ram_aa == 3'd0) aa_wrap = 1;
                saw_aa7 = (ram_aa == 3'd7);
            end
            if (i >= 30 && wr_ready && rd_valid) steady++;
            if (rd_valid) begin
                exp_w = (q.size() != 0) ? q.pop_front() : 16'hxxxx;
                chk("drain_order", 32'(rd_data), 32'(exp_w));
            end
            if (wr_ready) begin
                q.push_back(wr_data);
                accepted++;
            end
        end
        chk("drain_ab_wrap", 32'(ab_wrap), 1);
        chk("drain_aa_wrap", 32'(aa_wrap), 1);
        chk("drain_steady", 32'(steady), 10);

        // Random handshakes against the scoreboard
        pops = 0; cyc = 0; prev_stall = 0; prev_data = '0;
        while (pops < 10000 && cyc < 60000) begin
            @(negedge clk);
            wr_valid = 1'($urandom_range(0, 1));
            wr_data  = 16'($urandom);
            rd_ready = 1'($urandom_range(0, 1));
            #1;
            cyc++;
            chk("rand_count", 32'(count), 32'(q.size()));
            if (prev_stall) begin
                chk("rand_stall_valid", 32'(rd_valid), 1);
                chk("rand_stall_data", 32'(rd_data), 32'(prev_data));
            end
            if (rd_valid && rd_ready) begin
                exp_w = (q.size() != 0) ? q.pop_front() : 16'hxxxx;
                chk("rand_data", 32'(rd_data), 32'(exp_w));
                pops++;
            end
            if (wr_valid && wr_ready) q.push_back(wr_data);
            prev_stall = rd_valid && !rd_ready;
            prev_data  = rd_data;
        end
        chk("rand_completed", 32'(pops >= 10000), 1);

        // Asynchronous reset in the middle of a burst
        @(negedge clk); clr = 1'b1; wr_valid = 1'b0; rd_ready = 1'b0;
        q.delete();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            clr = 1'b0; wr_valid = 1'b1; wr_data = 16'(16'h100 + i); rd_ready = 1'b0;
        end
        #1;
        chk("pre_arst_rd_valid", 32'(rd_valid), 1);
        chk("pre_arst_cenb", 32'(ram_cenb), 0);
        #1; rstn = 1'b0;
        #1;
        chk("arst_cena", 32'(ram_cena), 1);
        chk("arst_cenb", 32'(ram_cenb), 1);
        chk("arst_rd_valid", 32'(rd_valid), 0);
        chk("arst_count", 32'(count), 0);
        @(negedge clk); rstn = 1'b1; wr_valid = 1'b0;
        idle(2);
        @(negedge clk); wr_valid = 1'b1; wr_data = 16'h55; rd_ready = 1'b1;
        got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk); wr_valid = 1'b0; rd_ready = 1'b1;
            #1;
            if (rd_valid) begin
                got = 1;
                chk("post_arst_data", 32'(rd_data), 16'h55);
                chk("post_arst_latency", 32'(i), 2);
            end
        end
        chk("post_arst_seen", 32'(got), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
